// File: rtl/dwt_axis_packer.sv
// rtl/dwt_axis_packer.sv - packs DWT samples into LANES-wide AXI-Stream beats through a FWFT FIFO
// Optional frame counter compiled in with PACKER_FRAME_CNT_EN.
module dwt_axis_packer #(
    parameter int IN_WIDTH   = 8,
    parameter int LANES      = 4,
    parameter int HEIGHT     = 256,
    parameter int WIDTH      = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_valid,
    output logic [IN_WIDTH*LANES-1:0] m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      overflow,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam int FRAME = HEIGHT * WIDTH;
    localparam int BW    = IN_WIDTH * LANES;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SW    = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(FRAME - 1);

    generate
        if ((FRAME % LANES) != 0) begin : g_bad_frame
            $error("HEIGHT*WIDTH must be a multiple of LANES");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic {IDLE, PACK} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [SW-1:0]   smp_q, smp_d;
    logic [BW-1:0]   beat_q, beat_word;
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [BW:0]     mem_q [FIFO_DEPTH];
    logic [BW:0]     head;
    logic            overflow_q, frame_done_q;
    logic            empty, full, pop, beat_done, push, drop, last_smp;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign pop       = !empty && m_tready;
    assign beat_done = in_valid && (lane_q == LANE_LAST);
    // A full FIFO still takes the beat when the head leaves on the same edge.
    assign push      = beat_done && (!full || pop);
    assign drop      = beat_done && full && !pop;
    assign last_smp  = (smp_q == SMP_LAST);

    always_comb begin
        beat_word = beat_q;
        beat_word[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = in_data;
    end

    always_comb begin
        lane_d  = lane_q;
        smp_d   = smp_q;
        state_d = state_q;
        if (in_valid) begin
            lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
            smp_d  = last_smp ? '0 : smp_q + 1'b1;
        end
        case (state_q)
            IDLE:    if (in_valid && !last_smp) state_d = PACK;
            PACK:    if (in_valid && last_smp)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters advance even on a dropped beat so frame alignment survives overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            smp_q        <= '0;
            beat_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            smp_q        <= smp_d;
            if (in_valid) beat_q <= beat_word;
            if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)     overflow_q <= 1'b1;
            frame_done_q <= pop && head[BW];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {last_smp, beat_word};
    end

`ifdef PACKER_FRAME_CNT_EN
    logic [15:0] frame_count_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     frame_count_q <= '0;
        else if (pop && head[BW])     frame_count_q <= frame_count_q + 16'd1;
    end
    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'd0;
`endif

    assign m_tvalid   = !empty;
    assign m_tdata    = empty ? '0 : head[BW-1:0];
    assign m_tlast    = !empty && head[BW];
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dwt_axis_packer.sv
// tb/tb_dwt_axis_packer.sv - scoreboard bench for dwt_axis_packer (4x4 frame, 4 lanes, depth 4)
module tb_dwt_axis_packer;

    localparam int DEPTH = 4;
`ifdef PACKER_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        overflow;
    logic        frame_done;
    logic [15:0] frame_count;

    int total = 0;
    int bad   = 0;

    logic [32:0] q[$];
    logic [31:0] beat_m;
    int          lane_m, smp_m, fc_exp, fd_seen;
    logic        ovf_exp, fd_exp, fd_next;
    logic [7:0]  din;

    dwt_axis_packer #(
        .IN_WIDTH(8), .LANES(4), .HEIGHT(4), .WIDTH(4), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .overflow(overflow), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: inputs are stable at the falling edge, so the model settles
    // the pop and then the push that the next rising edge will perform.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            lane_m  = 0;
            smp_m   = 0;
            ovf_exp = 1'b0;
            fd_exp  = 1'b0;
            fc_exp  = 0;
            beat_m  = '0;
        end else begin
            chk("tvalid", m_tvalid, q.size() != 0);
            chk("overflow", overflow, ovf_exp);
            chk("frame_done", frame_done, fd_exp);
            chk("frame_count", frame_count, FC_EN ? fc_exp : 0);
            if (frame_done) fd_seen++;
            if (q.size() != 0) begin
                chk("tdata", m_tdata, q[0][31:0]);
                chk("tlast", m_tlast, q[0][32]);
            end
            fd_next = 1'b0;
            if (m_tvalid && m_tready && q.size() != 0) begin
                fd_next = q[0][32];
                void'(q.pop_front());
            end
            if (fd_next) fc_exp = (fc_exp + 1) % 65536;
            fd_exp = fd_next;
            if (in_valid) begin
                beat_m[lane_m*8 +: 8] = in_data;
                if (lane_m == 3) begin
                    if (q.size() < DEPTH) q.push_back({smp_m == 15, beat_m});
                    else                  ovf_exp = 1'b1;
                end
                lane_m = (lane_m + 1) % 4;
                smp_m  = (smp_m + 1) % 16;
            end
        end
    end

    task automatic send(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = din;
            m_tready = rdy;
            din      = din + 8'd1;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            m_tready = rdy;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_count", frame_count, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; m_tready = 1'b0;
        din = '0; fd_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_tvalid", m_tvalid, 1'b0);
        chk("init_tdata", m_tdata, 32'h0);
        chk("init_overflow", overflow, 1'b0);
        chk("init_frame_count", frame_count, 16'h0);
        rst = 1'b1;

        // Straight frame, sink always ready
        din = 8'h00;
        send(16, 1'b1);
        idle(6, 1'b1);
        chk("t1_frames", fd_seen, 1);
        chk("t1_drained", q.size(), 0);

        // Stall for a whole frame (fills FIFO exactly), then release
        send(16, 1'b0);
        idle(3, 1'b0);
        chk("t2_full_valid", m_tvalid, 1'b1);
        idle(10, 1'b1);
        chk("t2_overflow", overflow, 1'b0);
        chk("t2_drained", q.size(), 0);

        // Fifth beat with FIFO full and no pop is dropped
        send(20, 1'b0);
        idle(2, 1'b0);
        chk("t3_overflow", overflow, 1'b1);
        send(12, 1'b1);
        send(16, 1'b1);
        idle(8, 1'b1);
        chk("t3_overflow_sticky", overflow, 1'b1);
        chk("t3_drained", q.size(), 0);

        // Reset mid-frame with a beat pending in the FIFO
        send(6, 1'b0);
        pulse_reset();
        din = 8'h40;
        send(16, 1'b1);
        idle(8, 1'b1);
        chk("t4_drained", q.size(), 0);

        // Full FIFO, pop and completing beat on the same edge
        send(19, 1'b0);
        send(1, 1'b1);
        send(12, 1'b1);
        idle(10, 1'b1);
        chk("t6_no_drop", overflow, 1'b0);
        chk("t6_drained", q.size(), 0);

        // Three frames from a clean reset
        pulse_reset();
        fd_seen = 0;
        send(48, 1'b1);
        idle(8, 1'b1);
        chk("t5_frames", fd_seen, 3);
        chk("t5_frame_count", frame_count, FC_EN ? 16'd3 : 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dwt_axis_packer.md
DWT_AXIS_PACKER -- requirements
Module: dwt_axis_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: sample width in bits.
REQ-002 SHALL have parameter LANES, default 4: samples packed per output beat.
REQ-003 SHALL have parameter HEIGHT, default 256: frame rows.
REQ-004 SHALL have parameter WIDTH, default 256: frame columns.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: beat FIFO depth, power of 2, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port in_data, input, IN_WIDTH bits: DWT coefficient sample.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data valid; no backpressure toward source.
REQ-010 SHALL have port m_tdata, output, IN_WIDTH*LANES bits: packed beat.
REQ-011 SHALL have port m_tvalid, output, 1 bit: beat available.
REQ-012 SHALL have port m_tready, input, 1 bit: sink accepts beat.
REQ-013 SHALL have port m_tlast, output, 1 bit: beat holds last sample of frame.
REQ-014 SHALL have port overflow, output, 1 bit: sticky, set when a beat was dropped.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse.
REQ-016 SHALL have port frame_count, output, 16 bits: completed-frame count.

Function
REQ-017 SHALL accept a sample on every rising clk edge with in_valid=1.
REQ-018 SHALL place sample k of a beat in m_tdata bits [k*IN_WIDTH +: IN_WIDTH], lane 0 at the LSB.
REQ-019 SHALL write the beat into the FIFO on the edge that samples lane LANES-1; m_tvalid SHALL rise in the following cycle (1-cycle latency, first-word fall-through).
REQ-020 SHALL count samples 0..HEIGHT*WIDTH-1, wrapping to 0 after the last; HEIGHT*WIDTH SHALL be a multiple of LANES (elaboration error otherwise).
REQ-021 SHALL store a tlast bit with each beat, set when the beat holds sample HEIGHT*WIDTH-1.
REQ-022 SHALL hold m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0; a beat is consumed when m_tvalid and m_tready are both 1.
REQ-023 SHALL run an FSM IDLE->PACK on first in_valid; PACK->IDLE after the frame's last sample is written.
REQ-024 SHALL, when FIFO full with a same-cycle pop, accept the write (no drop).
REQ-025 SHALL, when FIFO full without a pop, drop the beat, set overflow, and still advance lane and sample counters, preserving frame alignment.
REQ-026 SHALL pulse frame_done for exactly one cycle on the edge a tlast beat is consumed.
REQ-027 SHALL deassert m_tvalid when the FIFO is empty; the FIFO SHALL never underflow.

Reset
REQ-028 SHALL, while rst=0, asynchronously clear FIFO pointers, lane counter, sample counter and FSM (IDLE); force m_tvalid=0, m_tlast=0, m_tdata=0, overflow=0, frame_done=0, frame_count=0.
REQ-029 SHALL discard a partial beat and any FIFO contents on reset mid-frame; the next accepted sample after release SHALL be treated as frame sample 0, lane 0.

Configuration
REQ-030 SHALL compile frame counting only when PACKER_FRAME_CNT_EN is defined: frame_count SHALL then increment by 1 on each frame_done and wrap from 65535 to 0.
REQ-031 SHALL, without PACKER_FRAME_CNT_EN, tie frame_count to constant 0 with no counter logic; all other behaviour SHALL be unchanged.

Verification (IN_WIDTH=8, LANES=4, HEIGHT=WIDTH=4, FIFO_DEPTH=4)
REQ-032 SHALL check: 16 consecutive samples 0x00..0x0F, m_tready=1 -> beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; m_tlast=1 only on the 4th beat; one frame_done pulse.
REQ-033 SHALL check: m_tready=0 for 16 samples, then 1 -> the 4 beats emerge in order, stable while stalled, overflow=0.
REQ-034 SHALL check: m_tready=0 for 20 samples (5 beats) -> overflow=1 and stays 1; the 5th beat is dropped; on release the next frame's tlast lands on its 4th beat.
REQ-035 SHALL check: rst=0 pulsed after 6 samples -> outputs zero immediately; the next 16 samples yield 4 correct beats with tlast on the 4th.
REQ-036 SHALL check: with PACKER_FRAME_CNT_EN, 3 frames -> frame_count=3; without it, frame_count=0 throughout.
REQ-037 SHALL check: full FIFO with m_tready=1 and a beat completing in the same cycle -> no drop, overflow stays 0.
